// File: rtl/alu_control_mc.sv
// alu_control_mc: registered RV32 ALU-control decoder with RV32M start/stall/done sequencing and illegal flagging.
// Define ALU_CTRL_MEXT_EN to build the RV32M decode and the BUSY/DONE sequencer.
module alu_control_mc #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            op_valid_o,
  output logic            mc_start_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            illegal_o
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] base, code;
  logic legal, mc, mext;
`ifdef ALU_CTRL_MEXT_EN
  assign mext = 1'b1;
`else
  assign mext = 1'b0;
`endif
  // Plain funct3 mapping shared by R-type (funct7=0) and the I-type ops.
  always_comb begin
    base = 5'h00;
    case (funct3_i)
      3'b000: base = 5'h00;
      3'b001: base = 5'h04;
      3'b010: base = 5'h09;
      3'b011: base = 5'h0A;
      3'b100: base = 5'h07;
      3'b101: base = 5'h05;
      3'b110: base = 5'h03;
      default: base = 5'h06;
    endcase
  end
  always_comb begin
    code  = 5'h00;
    legal = 1'b0;
    mc    = 1'b0;
    case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == 7'h00) begin
          code  = base;
          legal = 1'b1;
        end else if (funct7_i == 7'h20 && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
          code  = funct3_i[2] ? 5'h08 : 5'h01;
          legal = 1'b1;
        end else if (funct7_i == 7'h01 && mext) begin
          code  = {2'b10, funct3_i};
          legal = 1'b1;
          mc    = 1'b1;
        end
      end
      3'b001: begin
        if (funct3_i == 3'b001) begin
          code  = 5'h04;
          legal = funct7_i == 7'h00;
        end else if (funct3_i == 3'b101) begin
          code  = (funct7_i == 7'h20) ? 5'h08 : 5'h05;
          legal = funct7_i == 7'h00 || funct7_i == 7'h20;
        end else begin
          code  = base;
          legal = 1'b1;
        end
      end
      3'b010: legal = 1'b1;
      3'b011: begin
        code  = 5'h01;
        legal = 1'b1;
      end
      3'b111: begin
        code  = 5'h02;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      ALU_Operation_o <= '0;
      op_valid_o      <= 1'b0;
      mc_start_o      <= 1'b0;
      stall_o         <= 1'b0;
      done_o          <= 1'b0;
      illegal_o       <= 1'b0;
    end else begin
      op_valid_o <= 1'b0;
      mc_start_o <= 1'b0;
      done_o     <= 1'b0;
      illegal_o  <= 1'b0;
      if (flush_i) begin
        state           <= IDLE;
        cnt             <= '0;
        stall_o         <= 1'b0;
        ALU_Operation_o <= '0;
      end else if (state == BUSY) begin
        if (cnt == '0) begin
          state   <= DONE;
          stall_o <= 1'b0;
          done_o  <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else begin
        state <= IDLE;
        if (valid_i) begin
          ALU_Operation_o <= legal ? OP_W'(code) : '0;
          op_valid_o      <= legal;
          illegal_o       <= !legal;
          if (legal && mc) begin
            state      <= BUSY;
            mc_start_o <= 1'b1;
            stall_o    <= 1'b1;
            cnt        <= funct3_i[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed and randomized checks of alu_control_mc against a cycle-level reference model.
module tb_alu_control_mc;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
  logic [6:0] funct7_i = '0;
  logic [2:0] ALU_Op_i = '0, funct3_i = '0;
  logic [4:0] ALU_Operation_o;
  logic       op_valid_o, mc_start_o, stall_o, done_o, illegal_o;
  int errors = 0, checks = 0;
  int m_op = 0, m_rem = 0;
  bit m_opv = 0, m_start = 0, m_stall = 0, m_done = 0, m_ill = 0;
  int r_tab[8] = '{0, 4, 9, 10, 7, 5, 3, 6};
  always #5 clk = ~clk;
  alu_control_mc #(.OP_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i),
    .funct3_i(funct3_i), .flush_i(flush_i), .ALU_Operation_o(ALU_Operation_o),
    .op_valid_o(op_valid_o), .mc_start_o(mc_start_o), .stall_o(stall_o), .done_o(done_o),
    .illegal_o(illegal_o)
  );
  task automatic check(string tag, logic [31:0] got, int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected code, or -1 when the encoding is undecodable.
  function automatic int ref_code(logic [2:0] op, logic [6:0] f7, logic [2:0] f3, output bit mc);
    mc = 0;
    case (op)
      3'd0: begin
        if (f7 == 7'd0) return r_tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return 1;
        if (f7 == 7'h20 && f3 == 3'd5) return 8;
        if (f7 == 7'h01 && MEXT) begin
          mc = 1;
          return 16 + int'(f3);
        end
        return -1;
      end
      3'd1: begin
        if (f3 == 3'd1) return (f7 == 0) ? 4 : -1;
        if (f3 == 3'd5) return (f7 == 0) ? 5 : (f7 == 7'h20) ? 8 : -1;
        return r_tab[f3];
      end
      3'd2: return 0;
      3'd3: return 1;
      3'd7: return 2;
      default: return -1;
    endcase
  endfunction
  task automatic model_reset();
    m_op = 0; m_rem = 0; m_opv = 0; m_start = 0; m_stall = 0; m_done = 0; m_ill = 0;
  endtask
  task automatic model_edge();
    bit mc;
    int c;
    m_opv = 0; m_start = 0; m_done = 0; m_ill = 0;
    if (flush_i) begin
      m_op = 0; m_stall = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_stall = m_rem > 0;
      m_done = m_rem == 0;
    end else if (valid_i) begin
      c = ref_code(ALU_Op_i, funct7_i, funct3_i, mc);
      if (c < 0) begin
        m_ill = 1; m_op = 0;
      end else begin
        m_op = c; m_opv = 1;
        if (mc) begin
          m_start = 1; m_stall = 1;
          m_rem = funct3_i[2] ? DIV_LAT : MUL_LAT;
        end
      end
    end
  endtask
  task automatic cmp_all();
    check("op", ALU_Operation_o, m_op);
    check("op_valid", op_valid_o, m_opv);
    check("mc_start", mc_start_o, m_start);
    check("stall", stall_o, m_stall);
    check("done", done_o, m_done);
    check("illegal", illegal_o, m_ill);
  endtask
  task automatic step(bit v, logic [2:0] op, logic [6:0] f7, logic [2:0] f3, bit fl);
    @(negedge clk);
    valid_i = v; ALU_Op_i = op; funct7_i = f7; funct3_i = f3; flush_i = fl;
    @(posedge clk);
    model_edge();
    #1 cmp_all();
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 7'd0, 3'd0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    cmp_all();
    @(negedge clk) reset = 1'b0;
    step(1, 3'd0, 7'h20, 3'd0, 0);
    check("t1_sub", ALU_Operation_o, 1);
    check("t1_opv", op_valid_o, 1);
    step(1, 3'd1, 7'h20, 3'd5, 0);
    check("t2_sra", ALU_Operation_o, 8);
    step(1, 3'd1, 7'h02, 3'd5, 0);
    check("t2_ill", illegal_o, 1);
    check("t2_op0", ALU_Operation_o, 0);
    step(1, 3'd7, 7'h00, 3'd0, 0);
    check("lui", ALU_Operation_o, 2);
    step(1, 3'd5, 7'h00, 3'd0, 0);
    check("aluop5_ill", illegal_o, 1);
    step(1, 3'd0, 7'h01, 3'd4, 0);
    if (MEXT) begin
      check("div_start", mc_start_o, 1);
      idle(DIV_LAT + 2);
      step(1, 3'd0, 7'h01, 3'd0, 0);
      check("t3_mul", ALU_Operation_o, 16);
      check("t3_start", mc_start_o, 1);
      step(1, 3'd0, 7'h00, 3'd0, 0);
      check("t3_ign", op_valid_o, 0);
      idle(1);
      check("t3_stall3", stall_o, 1);
      idle(1);
      check("t3_done", done_o, 1);
      check("t3_op", ALU_Operation_o, 16);
      step(1, 3'd0, 7'h01, 3'd4, 0);
      idle(4);
      step(0, 3'd0, 7'h00, 3'd0, 1);
      check("t4_stall", stall_o, 0);
      check("t4_op", ALU_Operation_o, 0);
      idle(DIV_LAT + 4);
      step(1, 3'd0, 7'h01, 3'd5, 0);
      idle(9);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      cmp_all();
      @(negedge clk) reset = 1'b0;
      step(1, 3'd0, 7'h00, 3'd0, 0);
      check("t5_add", op_valid_o, 1);
    end else begin
      check("t6_ill", illegal_o, 1);
      check("t6_stall", stall_o, 0);
      idle(2);
    end
    for (int i = 0; i < 600; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, 3'($urandom), f7, 3'($urandom), $urandom_range(0, 39) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
